// File: rtl/bsearch_ctrl.sv
// Binary-search controller: walks a sorted synchronous-read RAM through an external comparator.
// Latency 3 cycles per probe (+1 range check when not found); start ignored while busy.
// Optional probe counter output enabled by defining BSEARCH_STATS_EN.
module bsearch_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_eq,
    input  logic              cmp_gt,
    input  logic              cmp_lt,
    output logic              busy,
    output logic              done,
    output logic              found,
`ifdef BSEARCH_STATS_EN
    output logic [ADDR_W+1:0] probes,
`endif
    output logic [ADDR_W-1:0] index
);

    localparam int RW = ADDR_W + 2;
    localparam logic [RW-1:0] MAX_LEN = RW'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RW-1:0]     lo;
    logic [RW-1:0]     hi;
    logic [RW-1:0]     mid_q;
    logic [RW-1:0]     mid_w;
    logic [RW-1:0]     len_ext;
    logic [DATA_W-1:0] key_q;

    assign len_ext = {1'b0, len};
    // Range bounds are at most 2^ADDR_W, so the sum cannot overflow RW bits.
    assign mid_w   = (lo + hi) >> 1;

    assign cmp_a = mem_rdata;
    assign cmp_b = key_q;
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ADDR;
            S_ADDR: state_nxt = (lo >= hi) ? S_DONE : S_WAIT;
            S_WAIT: state_nxt = S_CMP;
            S_CMP:  state_nxt = cmp_eq ? S_DONE : S_ADDR;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo       <= '0;
            hi       <= '0;
            mid_q    <= '0;
            key_q    <= '0;
            mem_addr <= '0;
            found    <= 1'b0;
            index    <= '0;
`ifdef BSEARCH_STATS_EN
            probes   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_q <= key;
                        lo    <= '0;
                        hi    <= (len_ext > MAX_LEN) ? MAX_LEN : len_ext;
                        found <= 1'b0;
                        index <= '0;
`ifdef BSEARCH_STATS_EN
                        probes <= '0;
`endif
                    end
                end
                S_ADDR: begin
                    if (lo < hi) begin
                        mid_q    <= mid_w;
                        mem_addr <= mid_w[ADDR_W-1:0];
                    end
                end
                S_CMP: begin
`ifdef BSEARCH_STATS_EN
                    probes <= probes + RW'(1);
`endif
                    // eq beats lt beats gt; no flag at all narrows like gt.
                    if (cmp_eq) begin
                        found <= 1'b1;
                        index <= mid_q[ADDR_W-1:0];
                    end else if (cmp_lt) begin
                        lo <= mid_q + RW'(1);
                    end else if (cmp_gt) begin
                        hi <= mid_q;
                    end else begin
                        hi <= mid_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bsearch_ctrl.md
# bsearch_ctrl

Sequential binary-search controller that drives operands into the team's 32-bit unsigned magnitude comparator and acts on its eq/gt/lt result flags. It searches an ascending-sorted word array in a synchronous-read memory for a key, and reports found/not-found plus the matching index. It sits between the comparator and a small lookup RAM, and is the initiator side of the comparator's A/B → eq/gt/lt interface.

## Interface
- DATA_W, 32, width of key, memory words and comparator operands
- ADDR_W, 5, memory address width; max array length 2^ADDR_W
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin search; sampled only in IDLE
- key  input  DATA_W  value to find; latched on accepted start
- len  input  ADDR_W+1  number of valid words, 0..2^ADDR_W; latched on accepted start
- mem_addr  output  ADDR_W  read address to memory
- mem_rdata  input  DATA_W  read data, valid one cycle after mem_addr
- cmp_a  output  DATA_W  comparator operand A = mem_rdata (combinational pass-through)
- cmp_b  output  DATA_W  comparator operand B = latched key
- cmp_eq, cmp_gt, cmp_lt  input  1 each  comparator result for cmp_a vs cmp_b
- busy  output  1  high from accepted start until DONE is left
- done  output  1  one-cycle pulse in DONE
- found  output  1  result; held until next accepted start
- index  output  ADDR_W  matching address when found, else 0; held like found

## Operation
- States: IDLE, ADDR, WAIT, CMP, DONE.
- Range is lo/hi, each ADDR_W+2 bits, half-open [lo,hi). On start: lo=0, hi=len, key latched, found=0, index=0, go to ADDR.
- ADDR: if lo>=hi, go to DONE (not found). Otherwise mid=(lo+hi)>>1 (computed at ADDR_W+2 bits, no overflow), mem_addr=mid[ADDR_W-1:0], go to WAIT.
- WAIT: hold mem_addr; go to CMP.
- CMP: mem_rdata is valid; flags are evaluated with priority eq > lt > gt.
  - eq: found=1, index=mid, go to DONE.
  - lt (word < key): lo=mid+1, go to ADDR.
  - gt: hi=mid, go to ADDR.
  - No flag asserted: treated as gt.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored while busy.
- len > 2^ADDR_W is clamped to 2^ADDR_W at latch time.
- Reset values: state IDLE; busy, done, found = 0; index, mem_addr = 0; lo, hi, key register = 0.
- Reset asserted mid-search returns the block to IDLE on the next edge. No done pulse is produced and found/index are cleared.

## Timing
- Cycle 0 is the edge that samples start; ADDR occupies cycle 1.
- Each probe costs 3 cycles (ADDR, WAIT, CMP).
- Found after P probes: done high in cycle 3P+1.
- Not found after P probes: done high in cycle 3P+2, because of the extra ADDR range check.
- len=0: done in cycle 2, zero probes.
- Maximum P is ADDR_W+1.
- A new start is accepted in the cycle after done (IDLE), giving back-to-back searches with one idle cycle.
- found and index are stable from the done cycle onward.

## Configuration
- BSEARCH_STATS_EN defined:
  - Adds output probes (ADDR_W+2 bits), cleared on accepted start and on rst.
  - Increments once per CMP cycle.
  - Holds its value with found until the next start.
- BSEARCH_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
Common setup: ADDR_W=5, memory holds mem[i]=2*i+10 for i=0..15, len=16, and the real comparator is connected.
- key=10 → found=1, index=0, probes=5 (mid 8,4,2,1,0), done in cycle 16.
- key=40 → found=1, index=15, probes=4 (mid 8,12,14,15), done in cycle 13.
- key=11 → found=0, index=0, probes=5, done in cycle 17. key=5 → found=0, probes=5, done in cycle 17.
- len=0 with any key → found=0, probes=0, done in cycle 2, no memory read issued.
- Mid-search and back-to-back behaviour:
  - Assert rst in cycle 4 of a key=40 search → next cycle IDLE, busy=0, found=0, no done pulse.
  - Then start with key=26 → found=1, index=8, probes=1, done in cycle 4.
  - Pulse start while busy → ignored, key unchanged.
